tcdm_sram_bridge: RTL and testbench

Single-bank L2 SRAM controller that sits directly downstream of the JTAG lint master on the TCDM/XBAR bus. It accepts TCDM requests (req/gnt, 1-cycle-per-beat, no response backpressure) and drives a raw single-port SRAM macro. It also returns TCDM responses with a fixed latency and flags out-of-range addresses. After reset, and on demand, it zero-fills the bank so debug-loaded images start from known contents.

---
 rtl/tcdm_sram_bridge.sv | 114 +++++++++++
 tb/tb_tcdm_sram_bridge.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_sram_bridge.sv
// tcdm_sram_bridge: TCDM-to-single-port-SRAM bank controller with zero-fill init and fixed-latency responses.
// Optional traffic counters are enabled by defining TCDM_SRAM_BRIDGE_STATS_EN.
module tcdm_sram_bridge #(
  parameter logic [31:0] BASE_ADDR  = 32'h1C00_0000,
  parameter int          BANK_WORDS = 32768,
  parameter int          SRAM_LAT   = 1,
  parameter int          ADDR_W     = $clog2(BANK_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              init_req_i,
  output logic              init_done_o,
  input  logic              tcdm_req_i,
  input  logic [31:0]       tcdm_add_i,
  input  logic              tcdm_wen_i,
  input  logic [31:0]       tcdm_wdata_i,
  input  logic [3:0]        tcdm_be_i,
  output logic              tcdm_gnt_o,
  output logic              tcdm_r_valid_o,
  output logic [31:0]       tcdm_r_rdata_o,
  output logic              tcdm_r_opc_o,
  output logic              sram_csn_o,
  output logic              sram_wen_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  output logic [3:0]        sram_be_o,
  input  logic [31:0]       sram_rdata_i
`ifdef TCDM_SRAM_BRIDGE_STATS_EN
  ,
  output logic [15:0]       rd_cnt_o,
  output logic [15:0]       wr_cnt_o,
  output logic [15:0]       err_cnt_o
`endif
);
  typedef enum logic [1:0] {INIT, RUN, DRAIN} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] fill_cnt;
  logic [31:0] off;
  logic in_range, accept, hit, busy, fill_last, init_st, v_out;
  logic [SRAM_LAT-1:0] pv, pr, pe;
  assign off       = tcdm_add_i - BASE_ADDR;
  assign in_range  = (tcdm_add_i >= BASE_ADDR) && (off < 32'(4 * BANK_WORDS));
  assign init_st   = state == INIT;
  assign accept    = (state == RUN) && tcdm_req_i;
  assign hit       = accept && in_range;
  assign busy      = (|pv) || accept;
  assign fill_last = fill_cnt == ADDR_W'(BANK_WORDS - 1);
  assign tcdm_gnt_o = accept;
  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT:    state_nxt = fill_last ? RUN : INIT;
      RUN:     state_nxt = !init_req_i ? RUN : (busy ? DRAIN : INIT);
      DRAIN:   state_nxt = (|pv) ? DRAIN : INIT;
      default: state_nxt = INIT;
    endcase
  end
  // Fill writes own the SRAM in INIT; otherwise the port follows the TCDM request directly.
  always_comb begin
    sram_csn_o   = !(init_st || hit);
    sram_wen_o   = init_st ? 1'b0 : (!hit || tcdm_wen_i);
    sram_addr_o  = init_st ? fill_cnt : off[ADDR_W+1:2];
    sram_wdata_o = init_st ? 32'h0 : tcdm_wdata_i;
    sram_be_o    = init_st ? 4'hF : tcdm_be_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= INIT;
      fill_cnt    <= '0;
      init_done_o <= 1'b0;
    end else begin
      state       <= state_nxt;
      fill_cnt    <= init_st ? fill_cnt + 1'b1 : '0;
      init_done_o <= state_nxt == RUN;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pv <= '0;
      pr <= '0;
      pe <= '0;
    end else begin
      pv[0] <= accept;
      pr[0] <= tcdm_wen_i;
      pe[0] <= !in_range;
      for (int i = 1; i < SRAM_LAT; i++) begin
        pv[i] <= pv[i-1];
        pr[i] <= pr[i-1];
        pe[i] <= pe[i-1];
      end
    end
  end
  assign v_out          = pv[SRAM_LAT-1];
  assign tcdm_r_valid_o = v_out;
  assign tcdm_r_opc_o   = v_out && pe[SRAM_LAT-1];
  assign tcdm_r_rdata_o = !v_out ? 32'h0 :
                          pe[SRAM_LAT-1] ? 32'hBADACCE5 :
                          pr[SRAM_LAT-1] ? sram_rdata_i : 32'h0;
`ifdef TCDM_SRAM_BRIDGE_STATS_EN
  logic clr;
  assign clr = !init_st && (state_nxt == INIT);
  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      rd_cnt_o  <= '0;
      wr_cnt_o  <= '0;
      err_cnt_o <= '0;
    end else begin
      rd_cnt_o  <= (hit && tcdm_wen_i && rd_cnt_o != 16'hFFFF) ? rd_cnt_o + 1'b1 : rd_cnt_o;
      wr_cnt_o  <= (hit && !tcdm_wen_i && wr_cnt_o != 16'hFFFF) ? wr_cnt_o + 1'b1 : wr_cnt_o;
      err_cnt_o <= (accept && !in_range && err_cnt_o != 16'hFFFF) ? err_cnt_o + 1'b1 : err_cnt_o;
    end
  end
`endif
endmodule

// File: tb/tb_tcdm_sram_bridge.sv
// tb_tcdm_sram_bridge: drives SRAM_LAT=1 and SRAM_LAT=2 bridges with identical traffic and scoreboards responses.
module tb_tcdm_sram_bridge;
  localparam logic [31:0] BASE = 32'h1C00_0000;
  logic clk = 1'b0, rst = 1'b1, init_req = 1'b0;
  logic req = 1'b0, wen = 1'b1;
  logic [31:0] add = '0, wdata = '0;
  logic [3:0] be = '0;
  logic init_done[2], gnt[2], rv[2], opc[2], csn[2], swen[2];
  logic [31:0] rdata[2], swdata[2], srdata[2];
  logic [3:0] saddr[2], sbe[2];
`ifdef TCDM_SRAM_BRIDGE_STATS_EN
  logic [15:0] rd_cnt[2], wr_cnt[2], err_cnt[2];
`endif
  typedef struct {int due; logic [31:0] rdata; logic opc;} exp_t;
  exp_t sq0[$], sq1[$];
  logic [31:0] mem[2][16];
  logic [31:0] q1[2], q2[2];
  logic [31:0] refm[16];
  int cyc = 0, checks = 0, errors = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    tcdm_sram_bridge #(.BASE_ADDR(BASE), .BANK_WORDS(16), .SRAM_LAT(g + 1)) u_dut (
      .clk_i(clk), .rst_i(rst), .init_req_i(init_req), .init_done_o(init_done[g]),
      .tcdm_req_i(req), .tcdm_add_i(add), .tcdm_wen_i(wen), .tcdm_wdata_i(wdata), .tcdm_be_i(be),
      .tcdm_gnt_o(gnt[g]), .tcdm_r_valid_o(rv[g]), .tcdm_r_rdata_o(rdata[g]), .tcdm_r_opc_o(opc[g]),
      .sram_csn_o(csn[g]), .sram_wen_o(swen[g]), .sram_addr_o(saddr[g]), .sram_wdata_o(swdata[g]),
      .sram_be_o(sbe[g]), .sram_rdata_i(srdata[g])
`ifdef TCDM_SRAM_BRIDGE_STATS_EN
      , .rd_cnt_o(rd_cnt[g]), .wr_cnt_o(wr_cnt[g]), .err_cnt_o(err_cnt[g])
`endif
    );
  end
  // SRAM macro models honouring byte enables, with 1- and 2-cycle read latency.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!csn[i]) begin
        if (!swen[i]) begin
          for (int b = 0; b < 4; b++)
            if (sbe[i][b]) mem[i][saddr[i]][8*b+:8] <= swdata[i][8*b+:8];
        end else q1[i] <= mem[i][saddr[i]];
      end
      q2[i] <= q1[i];
    end
  end
  assign srdata[0] = q1[0];
  assign srdata[1] = q2[1];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (rv[i]) begin
          exp_t e;
          if ((i == 0 ? sq0.size() : sq1.size()) == 0) chk("spurious_rsp", 32'(rv[i]), 32'h0);
          else begin
            if (i == 0) e = sq0.pop_front();
            else e = sq1.pop_front();
            chk($sformatf("rsp_cycle%0d", i), cyc, e.due);
            chk($sformatf("rsp_rdata%0d", i), rdata[i], e.rdata);
            chk($sformatf("rsp_opc%0d", i), 32'(opc[i]), 32'(e.opc));
          end
        end
      end
    end
  end
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic exp_gnt);
    exp_t e;
    logic inr;
    logic [31:0] o;
    logic [3:0] idx;
    req = 1'b1; wen = w; add = a; wdata = d; be = b;
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk($sformatf("gnt%0d", i), 32'(gnt[i]), 32'(exp_gnt));
    if (exp_gnt) begin
      o = a - BASE;
      inr = a >= BASE && o < 32'd64;
      idx = o[5:2];
      e.opc = 1'b0;
      e.rdata = 32'h0;
      if (!inr) begin
        e.opc = 1'b1;
        e.rdata = 32'hBADACCE5;
        for (int i = 0; i < 2; i++) chk($sformatf("oor_csn%0d", i), 32'(csn[i]), 32'h1);
      end else if (w) e.rdata = refm[idx];
      else for (int k = 0; k < 4; k++) if (b[k]) refm[idx][8*k+:8] = d[8*k+:8];
      e.due = cyc + 1;
      sq0.push_back(e);
      e.due = cyc + 2;
      sq1.push_back(e);
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask
  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic fill_chk(input int i, input int k);
    chk($sformatf("fill_done%0d_%0d", i, k), 32'(init_done[i]), 32'h0);
    chk($sformatf("fill_addr%0d_%0d", i, k), 32'(saddr[i]), 32'(k));
    chk($sformatf("fill_wr%0d_%0d", i, k), {30'h0, csn[i], swen[i]}, 32'h0);
    chk($sformatf("fill_data%0d_%0d", i, k), swdata[i], 32'h0);
    chk($sformatf("fill_be%0d_%0d", i, k), 32'(sbe[i]), 32'hF);
  endtask
  initial begin
    for (int k = 0; k < 16; k++) refm[k] = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_done", 32'(init_done[i]), 32'h0);
      chk("rst_gnt", 32'(gnt[i]), 32'h0);
      chk("rst_rsp", {29'h0, rv[i], opc[i], |rdata[i]}, 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      req = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        fill_chk(i, k);
        chk("fill_gnt", 32'(gnt[i]), 32'h0);
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
    for (int i = 0; i < 2; i++) chk("done_after_fill", 32'(init_done[i]), 32'h1);
    do_req(1'b1, 32'h1C00_0008, 32'h0, 4'hF, 1'b1);
    do_req(1'b0, 32'h1C00_0004, 32'hDEADBEEF, 4'hF, 1'b1);
    do_req(1'b1, 32'h1C00_0004, 32'h0, 4'hF, 1'b1);
    do_req(1'b0, 32'h1C00_000C, 32'h11223344, 4'hF, 1'b1);
    do_req(1'b0, 32'h1C00_000C, 32'h0000AB00, 4'b0010, 1'b1);
    do_req(1'b1, 32'h1C00_000C, 32'h0, 4'hF, 1'b1);
    chk("partial_ref", refm[3], 32'h1122AB44);
    do_req(1'b1, 32'h1C00_0040, 32'h0, 4'hF, 1'b1);
    do_req(1'b1, 32'h1C00_0004, 32'h0, 4'hF, 1'b1);
    do_req(1'b1, 32'h1BFF_FFFC, 32'h0, 4'hF, 1'b1);
    do_req(1'b0, 32'h1C00_0044, 32'h12345678, 4'hF, 1'b1);
    idle(3);
`ifdef TCDM_SRAM_BRIDGE_STATS_EN
    for (int i = 0; i < 2; i++) begin
      chk("stat_rd", 32'(rd_cnt[i]), 32'd4);
      chk("stat_wr", 32'(wr_cnt[i]), 32'd3);
      chk("stat_err", 32'(err_cnt[i]), 32'd3);
    end
`endif
    for (int k = 0; k < 4; k++) do_req(1'b0, BASE + 32'(4 * k), 32'h100 + 32'(k), 4'hF, 1'b1);
    for (int k = 0; k < 4; k++) do_req(1'b1, BASE + 32'(4 * k), 32'h0, 4'hF, 1'b1);
    do_req(1'b1, 32'h1C00_0007, 32'h0, 4'hF, 1'b1);
    do_req(1'b1, 32'h1C00_003C, 32'h0, 4'hF, 1'b1);
    idle(3);
    do_req(1'b1, 32'h1C00_0004, 32'h0, 4'hF, 1'b1);
    init_req = 1'b1;
    @(posedge clk); #1;
    init_req = 1'b0;
    req = 1'b1; wen = 1'b1; add = 32'h1C00_0008;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("drain_gnt", 32'(gnt[i]), 32'h0);
      chk("drain_done", 32'(init_done[i]), 32'h0);
    end
    @(posedge clk); #1;
    req = 1'b0;
    for (int k = 0; k < 16; k++) refm[k] = 32'h0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      fill_chk(0, k);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("fill_word5", 32'(saddr[0]), 32'd5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        fill_chk(i, k);
        chk("refill_rv", 32'(rv[i]), 32'h0);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 2; i++) chk("done_after_refill", 32'(init_done[i]), 32'h1);
`ifdef TCDM_SRAM_BRIDGE_STATS_EN
    for (int i = 0; i < 2; i++) chk("stat_clear", {rd_cnt[i], err_cnt[i]}, 32'h0);
`endif
    do_req(1'b1, 32'h1C00_0004, 32'h0, 4'hF, 1'b1);
    do_req(1'b0, 32'h1C00_0010, 32'hCAFEF00D, 4'hF, 1'b1);
    do_req(1'b1, 32'h1C00_0050, 32'h0, 4'hF, 1'b1);
    do_req(1'b1, 32'h1C00_0010, 32'h0, 4'hF, 1'b1);
    idle(4);
    chk("sq0_empty", 32'(sq0.size()), 32'h0);
    chk("sq1_empty", 32'(sq1.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
